// File: rtl/pwm_pkg.sv
// Shared definitions for PWM generation/capture blocks: FSM encodings and defaults.
package pwm_pkg;

   localparam int unsigned CNT_W_DEF       = 32;
   localparam int unsigned TIMEOUT_CYC_DEF = 2_000_000;
   localparam int unsigned CYC_PER_MS_50M  = 50_000;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_HIGH = 2'd1;
   localparam logic [1:0] ST_LOW  = 2'd2;

   typedef enum logic [1:0] {
      IDLE = ST_IDLE,
      HIGH = ST_HIGH,
      LOW  = ST_LOW
   } state_t;

endpackage

// File: rtl/pwm_edge_sync.sv
// Two-flop synchroniser for an asynchronous level plus one-cycle rise/fall strobes.
module pwm_edge_sync (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic s,
   output logic rise,
   output logic fall
);

   logic s1;
   logic prev;

   always_ff @(posedge clk) begin
      if (reset) begin
         s1   <= 1'b0;
         s    <= 1'b0;
         prev <= 1'b0;
      end else begin
         s1   <= din;
         s    <= s1;
         prev <= s;
      end
   end

   assign rise = s & ~prev;
   assign fall = ~s & prev;

endmodule

// File: rtl/pwm_capture.sv
// Measures high time and period of a PWM input in clk cycles, with loss-of-signal timeout.
module pwm_capture
   import pwm_pkg::*;
#(
   parameter int unsigned CNT_W       = CNT_W_DEF,
   parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             pwm_in,
   output logic [CNT_W-1:0] d_out,
   output logic [CNT_W-1:0] t_out,
   output logic             valid,
   output logic             timeout,
   output logic             active
);

   localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT_CYC);
   localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

   state_t           state, state_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic [CNT_W-1:0] d_cap, d_cap_nx;
   logic [CNT_W-1:0] d_nx, t_nx;
   logic             valid_nx, timeout_nx, active_nx;
   logic             rise, fall;
   logic             s_level_unused;

   // Level output is not needed here; the edge strobes carry all timing.
   pwm_edge_sync u_sync (
      .clk   (clk),
      .reset (reset),
      .din   (pwm_in),
      .s     (s_level_unused),
      .rise  (rise),
      .fall  (fall)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         cnt     <= '0;
         d_cap   <= '0;
         d_out   <= '0;
         t_out   <= '0;
         valid   <= 1'b0;
         timeout <= 1'b0;
         active  <= 1'b0;
      end else begin
         state   <= state_nx;
         cnt     <= cnt_nx;
         d_cap   <= d_cap_nx;
         d_out   <= d_nx;
         t_out   <= t_nx;
         valid   <= valid_nx;
         timeout <= timeout_nx;
         active  <= active_nx;
      end
   end

   // Next-state and output logic; the timeout compare outranks edge handling.
   always_comb begin
      state_nx   = state;
      cnt_nx     = cnt;
      d_cap_nx   = d_cap;
      d_nx       = d_out;
      t_nx       = t_out;
      valid_nx   = 1'b0;
      timeout_nx = 1'b0;
      active_nx  = active;

      if (!enable) begin
         state_nx  = IDLE;
         cnt_nx    = '0;
         active_nx = 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               cnt_nx = '0;
               if (rise) begin
                  cnt_nx   = ONE;
                  state_nx = HIGH;
               end
            end
            HIGH: begin
               if (cnt == TO_VAL) begin
                  state_nx   = IDLE;
                  cnt_nx     = '0;
                  timeout_nx = 1'b1;
                  active_nx  = 1'b0;
               end else begin
                  cnt_nx = cnt + ONE;
                  if (fall) begin
                     d_cap_nx = cnt;
                     state_nx = LOW;
                  end
               end
            end
            LOW: begin
               if (cnt == TO_VAL) begin
                  state_nx   = IDLE;
                  cnt_nx     = '0;
                  timeout_nx = 1'b1;
                  active_nx  = 1'b0;
               end else if (rise) begin
                  // Rise closes this period and opens the next one without a gap.
                  t_nx      = cnt;
                  d_nx      = d_cap;
                  valid_nx  = 1'b1;
                  active_nx = 1'b1;
                  cnt_nx    = ONE;
                  state_nx  = HIGH;
               end else begin
                  cnt_nx = cnt + ONE;
               end
            end
            default: begin
               state_nx = IDLE;
               cnt_nx   = '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pwm_capture.sv
// Self-checking bench for pwm_capture: table-driven PWM streams plus scoreboarded valid/timeout events.
module tb_pwm_capture;

   localparam int unsigned CNT_W = 32;
   localparam int unsigned TO    = 50;
   localparam int unsigned LAT   = 3;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             enable = 1'b0;
   logic             pwm_in = 1'b0;
   logic [CNT_W-1:0] d_out, t_out;
   logic             valid, timeout, active;

   pwm_capture #(.CNT_W(CNT_W), .TIMEOUT_CYC(TO)) dut (
      .clk     (clk),
      .reset   (reset),
      .enable  (enable),
      .pwm_in  (pwm_in),
      .d_out   (d_out),
      .t_out   (t_out),
      .valid   (valid),
      .timeout (timeout),
      .active  (active)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int unsigned d;
      int unsigned t;
      int unsigned when;
   } exp_t;

   typedef struct {
      int unsigned h;
      int unsigned l;
      int unsigned reps;
      int unsigned exp_d;
      int unsigned exp_t;
   } vec_t;

   exp_t        vq[$];
   int unsigned toq[$];
   int          n_vec = 0;
   int          n_err = 0;
   int unsigned last_d = 0, last_t = 0;
   bit          pend_ok = 1'b0;
   int unsigned pend_d = 0, pend_t = 0, last_rise = 0;
   vec_t        tbl[5];

   task automatic check_eq(input string name, input int unsigned act, input int unsigned req);
      n_vec++;
      if (act != req) begin
         n_err++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, req);
      end
   endtask

   // Scoreboard: pop expected valid/timeout events as the DUT produces them.
   always @(negedge clk) begin
      exp_t e;
      if (vq.size() > 0 && vq[0].when < cyc) begin
         e = vq.pop_front();
         check_eq("missing valid", 0, e.when);
      end
      if (toq.size() > 0 && toq[0] < cyc) begin
         check_eq("missing timeout", 0, toq.pop_front());
      end
      if (valid) begin
         if (vq.size() == 0) begin
            check_eq("unexpected valid", 1, 0);
         end else begin
            e = vq.pop_front();
            check_eq("valid cycle", cyc, e.when);
            check_eq("d_out", d_out, e.d);
            check_eq("t_out", t_out, e.t);
            check_eq("active after valid", 32'(active), 1);
            last_d = e.d;
            last_t = e.t;
         end
      end
      if (timeout) begin
         if (toq.size() == 0) begin
            check_eq("unexpected timeout", 1, 0);
         end else begin
            check_eq("timeout cycle", cyc, toq.pop_front());
            check_eq("active after timeout", 32'(active), 0);
            check_eq("d_out held on timeout", d_out, last_d);
            check_eq("t_out held on timeout", t_out, last_t);
         end
      end
   end

   task automatic step(input int unsigned n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drive_period(input int unsigned h, input int unsigned l,
                               input int unsigned ed, input int unsigned et);
      pwm_in = 1'b1;
      if (pend_ok) vq.push_back('{d: pend_d, t: pend_t, when: cyc + LAT});
      last_rise = cyc;
      step(h);
      pwm_in = 1'b0;
      step(l);
      pend_ok = 1'b1;
      pend_d  = ed;
      pend_t  = et;
   endtask

   // One 3/11 period with reset (kind 0) or enable-low (kind 1) pulsed while the FSM is in HIGH.
   task automatic abort_period(input int kind);
      pwm_in = 1'b1;
      if (pend_ok) vq.push_back('{d: pend_d, t: pend_t, when: cyc + LAT});
      last_rise = cyc;
      step(3);
      pwm_in = 1'b0;
      step(1);
      if (kind == 0) reset = 1'b1;
      else           enable = 1'b0;
      step(1);
      pend_ok = 1'b0;
      if (kind == 0) begin
         reset  = 1'b0;
         last_d = 0;
         last_t = 0;
      end else begin
         enable = 1'b1;
      end
      @(negedge clk);
      check_eq(kind == 0 ? "reset abort active" : "enable abort active", 32'(active), 0);
      check_eq(kind == 0 ? "reset abort d_out" : "enable abort d_out", d_out, last_d);
      check_eq(kind == 0 ? "reset abort t_out" : "enable abort t_out", t_out, last_t);
      check_eq("abort valid", 32'(valid), 0);
      step(6);
   endtask

   task automatic end_stream_timeout();
      toq.push_back(last_rise + LAT + TO);
      pend_ok = 1'b0;
      step(TO + 12);
      @(negedge clk);
      check_eq("active after loss", 32'(active), 0);
      step(1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      tbl[0] = '{h: 3, l: 8,  reps: 4, exp_d: 3, exp_t: 11};
      tbl[1] = '{h: 5, l: 5,  reps: 3, exp_d: 5, exp_t: 10};
      tbl[2] = '{h: 2, l: 8,  reps: 3, exp_d: 2, exp_t: 10};
      tbl[3] = '{h: 1, l: 1,  reps: 6, exp_d: 1, exp_t: 2};
      tbl[4] = '{h: 7, l: 20, reps: 2, exp_d: 7, exp_t: 27};

      step(3);
      @(negedge clk);
      check_eq("reset d_out", d_out, 0);
      check_eq("reset t_out", t_out, 0);
      check_eq("reset valid", 32'(valid), 0);
      check_eq("reset timeout", 32'(timeout), 0);
      check_eq("reset active", 32'(active), 0);
      step(1);
      reset  = 1'b0;
      enable = 1'b1;
      step(4);

      // Continuous stream through every table record, then let the input die.
      for (int i = 0; i < 5; i++) begin
         for (int r = 0; r < int'(tbl[i].reps); r++) begin
            drive_period(tbl[i].h, tbl[i].l, tbl[i].exp_d, tbl[i].exp_t);
         end
      end
      end_stream_timeout();

      // Single isolated 4-cycle pulse: timeout, no valid.
      pwm_in = 1'b1;
      last_rise = cyc;
      step(4);
      pwm_in = 1'b0;
      end_stream_timeout();

      // Stuck high from reset release.
      reset = 1'b1;
      step(1);
      reset  = 1'b0;
      last_d = 0;
      last_t = 0;
      pwm_in = 1'b1;
      last_rise = cyc;
      end_stream_timeout();
      pwm_in = 1'b0;
      step(6);

      // Reset and enable aborts in the middle of a 3/11 stream.
      for (int i = 0; i < 2; i++) drive_period(3, 8, 3, 11);
      abort_period(0);
      for (int i = 0; i < 3; i++) drive_period(3, 8, 3, 11);
      abort_period(1);
      for (int i = 0; i < 3; i++) drive_period(3, 8, 3, 11);
      end_stream_timeout();

      check_eq("leftover valid expectations", vq.size(), 0);
      check_eq("leftover timeout expectations", toq.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
